// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- bundle of the core request, memory bus and response signals of lsu_ctrl.
//   Core request : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata
//   Memory bus   : mem_req, mem_gnt, mem_we, mem_addr, mem_be, mem_wdata, mem_rvalid, mem_rdata
//   Response     : rsp_valid, rsp_rdata, rsp_err
// Modports: slave = the controller itself, master = the surrounding core/memory environment.
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- RV32I load/store unit controller.
// Accepts one core load/store at a time, checks funct3 and alignment, issues a single
// word-aligned memory access with byte enables and lane-replicated store data, extracts and
// extends load data, and returns a one-cycle response. ISSUE plus WAIT are bounded by TIMEOUT.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_ctrl_if.slave (core request, memory bus, response)
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255  // 1..1023
) (
   input  logic       clk,
   input  logic       rst_n,
   lsu_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e      r_state, w_state_nxt;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [9:0]  r_cnt, w_cnt_nxt;
   logic        r_err, w_err_nxt;
   logic [31:0] r_rdata, w_rdata_nxt;

   logic        w_legal;
   logic        w_last;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_shift;
   logic [31:0] w_load;

   // Legality is judged on the live request so an illegal one never reaches ISSUE.
   always_comb begin
      w_legal = 1'b0;
      if (bus.req_we) begin
         w_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                   (bus.req_funct3 == 3'b010);
      end else begin
         w_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                   (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                   (bus.req_funct3 == 3'b101);
      end
      if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
         w_legal = 1'b0;
      end
      if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
         w_legal = 1'b0;
      end
   end

   // Byte enables, replicated store data and extended load data from the registered request.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_wdata;
      w_shift = bus.mem_rdata >> {r_addr[1:0], 3'b000};
      w_load  = bus.mem_rdata;
      unique case (r_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
      unique case (r_funct3)
         3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_load = {24'd0, w_shift[7:0]};
         3'b101:  w_load = {16'd0, w_shift[15:0]};
         default: w_load = bus.mem_rdata;
      endcase
   end

   // Last permitted cycle of ISSUE+WAIT; without progress this cycle, abort.
   assign w_last = (r_cnt == 10'(TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_rdata_nxt = r_rdata;
      unique case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_cnt_nxt   = '0;
               w_rdata_nxt = '0;
               w_err_nxt   = ~w_legal;
               w_state_nxt = w_legal ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            w_cnt_nxt = r_cnt + 10'd1;
            if (bus.mem_gnt && r_we) begin
               w_state_nxt = RESP;
            end else if (w_last) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end else if (bus.mem_gnt) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt + 10'd1;
            if (bus.mem_rvalid) begin
               w_rdata_nxt = w_load;
               w_state_nxt = RESP;
            end else if (w_last) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else if ((r_state == IDLE) && bus.req_valid) begin
         r_we     <= bus.req_we;
         r_funct3 <= bus.req_funct3;
         r_addr   <= bus.req_addr;
         r_wdata  <= bus.req_wdata;
      end
   end

   // Outputs decode straight from the state so reset clears them without waiting for a clock.
   assign bus.req_ready = (r_state == IDLE);
   assign bus.mem_req   = (r_state == ISSUE);
   assign bus.mem_we    = (r_state == ISSUE) && r_we;
   assign bus.mem_be    = (r_state == ISSUE) ? w_be : 4'b0000;
   assign bus.mem_addr  = {r_addr[31:2], 2'b00};
   assign bus.mem_wdata = w_wdata;
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_err   = (r_state == RESP) && r_err;
   assign bus.rsp_rdata = (r_state == RESP) ? r_rdata : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Two instances share all inputs: u_dut (default TIMEOUT) carries the functional traffic,
// u_dut_to (TIMEOUT=4) is only examined during the abort scenarios; a reset re-aligns both.
module tb_lsu_ctrl;
   localparam int unsigned TO_SHORT = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   lsu_ctrl_if bus ();
   lsu_ctrl_if bus_to ();

   assign bus_to.req_valid  = bus.req_valid;
   assign bus_to.req_we     = bus.req_we;
   assign bus_to.req_funct3 = bus.req_funct3;
   assign bus_to.req_addr   = bus.req_addr;
   assign bus_to.req_wdata  = bus.req_wdata;
   assign bus_to.mem_gnt    = bus.mem_gnt;
   assign bus_to.mem_rvalid = bus.mem_rvalid;
   assign bus_to.mem_rdata  = bus.mem_rdata;

   lsu_ctrl u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   lsu_ctrl #(.TIMEOUT(TO_SHORT)) u_dut_to (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_to)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      bit ok;
      if (we) ok = (f3 <= 3'd2);
      else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      return ok && ((addr % acc_size(f3)) == 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] m;
      m = ((32'd1 << acc_size(f3)) - 32'd1) << addr[1:0];
      return m[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int unsigned n;
      n = acc_size(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rd);
      logic [31:0] v;
      logic [31:0] mask;
      int unsigned bits;
      if (acc_size(f3) == 4) return rd;
      bits = 8 * acc_size(f3);
      v    = rd >> (8 * addr[1:0]);
      mask = (32'd1 << bits) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;
   endtask

   task automatic reset_all();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
      check_eq("rst_ready_to", 32'(bus_to.req_ready), 32'd1);
      check_eq("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
   endtask

   // Drives one request at a negedge with u_dut idle; returns at a negedge with u_dut idle.
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata);
      bit legal;
      legal = is_legal(we, f3, addr);
      check_eq("ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.mem_rvalid = 1'b1;          // stray rvalid in IDLE must be ignored
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      clear_inputs();
      check_eq("ready_busy", 32'(bus.req_ready), 32'd0);
      if (!legal) begin
         check_eq("ill_mem_req", 32'(bus.mem_req), 32'd0);
         check_eq("ill_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("ill_rsp_err", 32'(bus.rsp_err), 32'd1);
         check_eq("ill_rsp_rdata", bus.rsp_rdata, 32'd0);
      end else begin
         for (int c = 0; c <= gnt_dly; c++) begin
            check_eq("iss_mem_req", 32'(bus.mem_req), 32'd1);
            check_eq("iss_mem_we", 32'(bus.mem_we), 32'(we));
            check_eq("iss_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            check_eq("iss_mem_be", 32'(bus.mem_be), 32'(exp_be(f3, addr)));
            if (we) check_eq("iss_mem_wdata", bus.mem_wdata, exp_wdata(f3, wdata));
            check_eq("iss_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            if (c == gnt_dly) begin
               bus.mem_gnt    = 1'b1;
               bus.mem_rvalid = 1'b1;  // rvalid in the grant cycle must be ignored
               bus.mem_rdata  = $urandom;
            end
            @(negedge clk);
            clear_inputs();
         end
         if (!we) begin
            for (int c = 0; c < rv_dly; c++) begin
               check_eq("wait_mem_req", 32'(bus.mem_req), 32'd0);
               check_eq("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
               @(negedge clk);
            end
            check_eq("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(negedge clk);
            clear_inputs();
         end
         check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("rsp_err", 32'(bus.rsp_err), 32'd0);
         check_eq("rsp_rdata", bus.rsp_rdata, we ? 32'd0 : exp_load(f3, addr, rdata));
      end
      @(negedge clk);
      check_eq("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
      check_eq("rsp_err_quiet", 32'(bus.rsp_err), 32'd0);
   endtask

   // Abort scenario on u_dut_to: no grant at all (store) or grant but no rvalid (load).
   task automatic timeout_txn(input logic we);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_0100;
      bus.req_wdata  = 32'h1234_5678;
      @(negedge clk);
      clear_inputs();
      for (int c = 0; c < int'(TO_SHORT); c++) begin
         check_eq("to_mem_req", 32'(bus_to.mem_req), (we || c == 0) ? 32'd1 : 32'd0);
         check_eq("to_rsp_valid", 32'(bus_to.rsp_valid), 32'd0);
         if (!we && c == 0) bus.mem_gnt = 1'b1;
         @(negedge clk);
         clear_inputs();
      end
      check_eq("to_mem_req_drop", 32'(bus_to.mem_req), 32'd0);
      check_eq("to_rsp_valid", 32'(bus_to.rsp_valid), 32'd1);
      check_eq("to_rsp_err", 32'(bus_to.rsp_err), 32'd1);
      check_eq("to_rsp_rdata", bus_to.rsp_rdata, 32'd0);
      @(negedge clk);
      check_eq("to_ready", 32'(bus_to.req_ready), 32'd1);
      reset_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      #1;
      check_eq("por_mem_req", 32'(bus.mem_req), 32'd0);
      check_eq("por_mem_we", 32'(bus.mem_we), 32'd0);
      check_eq("por_mem_be", 32'(bus.mem_be), 32'd0);
      check_eq("por_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("por_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_eq("por_rsp_rdata", bus.rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("por_ready", 32'(bus.req_ready), 32'd1);
      check_eq("por_no_rsp", 32'(bus.rsp_valid), 32'd0);

      // Directed cases
      do_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0);     // SB
      do_txn(1'b0, 3'b001, 32'h0000_2002, 32'd0, 0, 3, 32'h8001_0000);     // LH
      do_txn(1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 3, 32'h8001_0000);     // LHU
      do_txn(1'b0, 3'b010, 32'h0000_2001, 32'd0, 0, 0, 32'd0);             // LW misaligned
      do_txn(1'b1, 3'b001, 32'h0000_0005, 32'hFFFF, 0, 0, 32'd0);          // SH misaligned
      do_txn(1'b1, 3'b011, 32'h0000_0008, 32'h1, 0, 0, 32'd0);             // bad store funct3
      do_txn(1'b0, 3'b011, 32'h0000_0008, 32'h0, 0, 0, 32'd0);             // bad load funct3
      do_txn(1'b0, 3'b000, 32'h0000_3003, 32'd0, 2, 1, 32'h80FF_0000);     // LB lane 3

      // Reset mid-ISSUE and mid-WAIT
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_4000;
      @(negedge clk);
      clear_inputs();
      check_eq("mid_iss_req", 32'(bus.mem_req), 32'd1);
      reset_all();
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_4000;
      @(negedge clk);
      clear_inputs();
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      clear_inputs();
      reset_all();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         clear_inputs();
         check_eq("stale_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      do_txn(1'b1, 3'b010, 32'h0000_4004, 32'hCAFE_F00D, 1, 0, 32'd0);     // SW after reset

      // Timeouts on the short-TIMEOUT instance
      reset_all();
      timeout_txn(1'b1);
      timeout_txn(1'b0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         logic        r_we_t;
         logic [2:0]  f3;
         logic [31:0] a;
         r_we_t = 1'($urandom_range(0, 1));
         f3     = 3'($urandom_range(0, 7));
         a      = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_txn(r_we_t, f3, a, $urandom, int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles spent in ISSUE plus WAIT before an abort; legal range 1..1023.
REQ-002 The block SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have req_valid, input, 1: core request present.
REQ-005 The block SHALL have req_ready, output, 1: controller can accept a request.
REQ-006 The block SHALL have req_we, input, 1: 1 = store, 0 = load.
REQ-007 The block SHALL have req_funct3, input, 3: RV32I load/store funct3.
REQ-008 The block SHALL have req_addr, input, 32: byte address.
REQ-009 The block SHALL have req_wdata, input, 32: store data, right-aligned.
REQ-010 The block SHALL have mem_req, output, 1: memory access request.
REQ-011 The block SHALL have mem_gnt, input, 1: memory accepts the request this cycle.
REQ-012 The block SHALL have mem_we, output, 1: write strobe.
REQ-013 The block SHALL have mem_addr, output, 32: word-aligned address.
REQ-014 The block SHALL have mem_be, output, 4: byte enables.
REQ-015 The block SHALL have mem_wdata, output, 32: lane-replicated store data.
REQ-016 The block SHALL have mem_rvalid, input, 1: read data valid.
REQ-017 The block SHALL have mem_rdata, input, 32: read word.
REQ-018 The block SHALL have rsp_valid, output, 1: one-cycle completion pulse.
REQ-019 The block SHALL have rsp_rdata, output, 32: extended load result.
REQ-020 The block SHALL have rsp_err, output, 1: access fault or misalignment; qualified by rsp_valid.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, req_valid SHALL cause req_we, req_funct3, req_addr and req_wdata to be registered.
REQ-023 From IDLE, legal requests SHALL go to ISSUE; illegal requests SHALL go to RESP with rsp_err=1 and no memory access.
REQ-024 A request SHALL be illegal for: store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-025 mem_be SHALL be: byte -> one-hot 0001<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111. The same enables SHALL be driven for loads.
REQ-026 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-027 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-028 In ISSUE, mem_req SHALL be 1 and mem_we, mem_addr, mem_be and mem_wdata SHALL hold stable until a cycle with mem_gnt=1.
REQ-029 On grant, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-030 mem_rvalid SHALL be honoured only in WAIT and ignored in all other states, including the grant cycle.
REQ-031 In WAIT, mem_rvalid SHALL capture the selected lane: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged; the FSM SHALL then go to RESP.
REQ-032 A cycle counter SHALL clear on leaving IDLE and increment in ISSUE and WAIT; reaching TIMEOUT SHALL force RESP with rsp_err=1.
REQ-033 A timeout in ISSUE SHALL drop mem_req in the next cycle.
REQ-034 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE.
REQ-035 rsp_rdata SHALL be 0 for stores and errors.
REQ-036 rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-037 Latency: with mem_gnt=1 in the first ISSUE cycle, a store's rsp_valid SHALL occur 2 cycles after acceptance; a load's SHALL occur 1 cycle after mem_rvalid.
REQ-038 Back-to-back requests SHALL be accepted no sooner than the cycle after RESP.

Reset
REQ-039 rst_n=0 SHALL immediately force IDLE, counter 0, and mem_req, mem_we, mem_be, rsp_valid, rsp_err and rsp_rdata to 0, including mid-transaction.
REQ-040 After reset release, req_ready SHALL be 1 on the first clk edge, and no stale rsp_valid SHALL be issued.

Verification
REQ-041 SB addr=0x1003, wdata=0xAB, gnt immediate -> mem_be=1000, mem_addr=0x1000, mem_wdata=0xABABABAB, rsp_valid 2 cycles after acceptance, rsp_err=0.
REQ-042 LH addr=0x2002, rdata=0x8001_0000 after 3 wait cycles -> rsp_rdata=0xFFFF8001; same with LHU -> 0x00008001.
REQ-043 LW addr=0x2001 -> no mem_req, rsp_valid next cycle with rsp_err=1; same for SH addr=0x5 and funct3=011.
REQ-044 TIMEOUT=4, gnt held 0 -> mem_req high 4 cycles then 0, rsp_err=1; load granted but no rvalid -> same abort.
REQ-045 rst_n pulsed low during WAIT -> mem_req=0 and rsp_valid=0 immediately; a later mem_rvalid is ignored; a new SW completes normally.
REQ-046 mem_rvalid pulsed in IDLE and in the grant cycle -> ignored; response is taken from the first rvalid in WAIT.
